instruction_fetch: RTL and testbench

Fetch stage of the 2-bit-opcode microprocessor. It holds the PC and issues single-outstanding reads to instruction memory. Fetched words are buffered in a 2-entry queue that feeds the decode/control stage through a valid/ready handshake, and `op` is exposed directly for the control unit. Taken branches resolved downstream redirect the PC, flush the queue and discard any in-flight wrong-path response.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and fetch FSM states.
// The control unit imports the same opcode constants.
package cpu_pkg;

  localparam logic [1:0] OP_RTYPE  = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_STORE  = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 1;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO with registered head outputs and synchronous flush.
// The caller never pushes while full without popping, and never pops while empty.
module fetch_queue #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [PC_W-1:0]    pushPc,
  input  logic [INSTR_W-1:0] pushInstr,
  input  logic               pop,
  input  logic               flush,
  output logic [PC_W-1:0]    headPc,
  output logic [INSTR_W-1:0] headInstr,
  output logic [1:0]         count
);

  logic [PC_W-1:0]    tailPc;
  logic [INSTR_W-1:0] tailInstr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 2'd0;
      headPc    <= '0;
      headInstr <= '0;
      tailPc    <= '0;
      tailInstr <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            headPc    <= pushPc;
            headInstr <= pushInstr;
          end else begin
            tailPc    <= pushPc;
            tailInstr <= pushInstr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          headPc    <= tailPc;
          headInstr <= tailInstr;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; with two entries the old tail moves up.
          if (count == 2'd2) begin
            headPc    <= tailPc;
            headInstr <= tailInstr;
            tailPc    <= pushPc;
            tailInstr <= pushInstr;
          end else begin
            headPc    <= pushPc;
            headInstr <= pushInstr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding imem reads, 2-entry instruction queue to decode.
// Taken branches at handoff flush the queue, redirect the PC and discard in-flight wrong-path data.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter int              OFF_W    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [1:0]         op,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   branch_offset
);

  fetchState_e        state, stateNext;
  logic [PC_W-1:0]    pc, pcNext, reqAddr, target;
  logic [1:0]         count, countNext;
  logic               complete, handoff, redirect, push, pop;
  logic [PC_W-1:0]    headPc;
  logic [INSTR_W-1:0] headInstr;

  assign instr_valid = (count != 2'd0);
  assign instr       = headInstr;
  assign instr_pc    = headPc;
  assign op          = instr_valid ? headInstr[OP_MSB:OP_LSB] : 2'b00;

  assign imem_req  = (state != S_IDLE);
  assign imem_addr = reqAddr;

  assign complete = imem_req && imem_ready;
  assign handoff  = instr_valid && instr_ready;
  assign redirect = handoff && branch_taken;
  // A redirect wins over a same-cycle completion: that word is wrong-path.
  assign push     = (state == S_REQ) && complete && !redirect;
  assign pop      = handoff && !redirect;
  assign target   = headPc + PC_W'(1)
                  + {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};

  assign countNext = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    pcNext    = pc;
    stateNext = state;
    if (redirect)  pcNext = target;
    else if (push) pcNext = pc + PC_W'(1);
    case (state)
      S_IDLE: if (countNext <= 2'd1) stateNext = S_REQ;
      S_REQ: begin
        if (complete)      stateNext = (countNext <= 2'd1) ? S_REQ : S_IDLE;
        else if (redirect) stateNext = S_DROP;
      end
      S_DROP: if (complete) stateNext = S_REQ;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      reqAddr <= RESET_PC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      // The address of an accepted-but-incomplete request is frozen, even across a redirect.
      if (!(imem_req && !imem_ready)) reqAddr <= pcNext;
    end
  end

  fetch_queue #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pushPc   (pc),
    .pushInstr(imem_rdata),
    .pop      (pop),
    .flush    (redirect),
    .headPc   (headPc),
    .headInstr(headInstr),
    .count    (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: memory/decode models plus a program-order reference.
// The reference tracks expected fetch address, expected head PC and queue occupancy.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ready = 1'b0;
  logic [7:0] imem_rdata = 8'd0;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic [1:0] op;
  logic       branch_taken = 1'b0;
  logic [1:0] branch_offset = 2'd0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .PC_W(8), .INSTR_W(8), .OFF_W(2), .RESET_PC(8'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .op(op), .branch_taken(branch_taken), .branch_offset(branch_offset)
  );

  int tests = 0;
  int fails = 0;

  int waitLo = 0, waitHi = 0, readyPct = 100, brPct = 0;
  bit forceOn = 1'b0;
  logic [7:0] forcePc = 8'd0;
  logic [1:0] forceOff = 2'd0;

  logic [7:0] expPc, fetchExp, prevAddr;
  int mCount, waitLeft, sinceReset, hands;
  bit dropNext, memBusy, prevHeld;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Odd multiplier makes every address hold a distinct word.
  function automatic logic [7:0] memWord(input logic [7:0] a);
    return a * 8'd157 + 8'd61;
  endfunction

  function automatic logic [7:0] branchTarget(input logic [7:0] p, input logic [1:0] o);
    int s;
    s = o[1] ? int'(o) - 4 : int'(o);
    return 8'((int'(p) + 1 + s) & 255);
  endfunction

  task automatic doReset();
    reset_n = 1'b0;
    imem_ready = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    #1;
    checkEq("rstReq", imem_req, 0);
    checkEq("rstAddr", imem_addr, 0);
    checkEq("rstValid", instr_valid, 0);
    checkEq("rstInstr", instr, 0);
    checkEq("rstPc", instr_pc, 0);
    checkEq("rstOp", op, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expPc = 8'd0; fetchExp = 8'd0; mCount = 0;
    dropNext = 1'b0; memBusy = 1'b0; prevHeld = 1'b0;
    waitLeft = 0; sinceReset = 0;
  endtask

  task automatic runCycle();
    bit hand, comp, br;
    logic [1:0] off;
    logic [7:0] w;
    @(negedge clk);
    sinceReset++;
    if (sinceReset == 1) begin
      checkEq("firstReq", imem_req, 1);
      checkEq("firstAddr", imem_addr, 0);
    end
    if (prevHeld) begin
      checkEq("reqHold", imem_req, 1);
      checkEq("addrHold", imem_addr, prevAddr);
    end
    checkEq("valid", instr_valid, mCount != 0);
    if (mCount == 2) checkEq("reqWhenFull", imem_req, 0);
    if (!instr_valid) checkEq("opIdle", op, 0);

    if (imem_req && !memBusy) begin
      memBusy = 1'b1;
      waitLeft = $urandom_range(waitHi, waitLo);
    end
    imem_ready = memBusy && (waitLeft == 0);
    imem_rdata = memWord(imem_addr);

    instr_ready = ($urandom_range(99) < readyPct);
    hand = instr_valid && instr_ready;
    br = 1'b0;
    off = 2'($urandom_range(3));
    if (hand) begin
      hands++;
      w = memWord(expPc);
      checkEq("headPc", instr_pc, expPc);
      checkEq("headInstr", instr, w);
      checkEq("headOp", op, w[7:6]);
      if (forceOn && expPc == forcePc) begin
        br = 1'b1;
        off = forceOff;
        forceOn = 1'b0;
      end else begin
        br = ($urandom_range(99) < brPct);
      end
    end
    branch_taken = hand ? br : 1'($urandom_range(1));
    branch_offset = off;

    comp = imem_req && imem_ready;
    if (comp) begin
      if (dropNext) begin
        dropNext = 1'b0;
      end else begin
        checkEq("fetchAddr", imem_addr, fetchExp);
        fetchExp++;
        if (!(hand && br)) mCount++;
      end
    end
    if (hand) begin
      if (br) begin
        expPc = branchTarget(expPc, off);
        fetchExp = expPc;
        mCount = 0;
        if (imem_req && !imem_ready) dropNext = 1'b1;
      end else begin
        expPc++;
        mCount--;
      end
    end

    prevHeld = imem_req && !imem_ready;
    prevAddr = imem_addr;
    if (comp) memBusy = 1'b0;
    else if (memBusy) waitLeft--;
    @(posedge clk);
  endtask

  initial begin
    hands = 0;
    #1;
    doReset();

    // Zero-wait memory, decode always ready: one handoff per cycle from cycle 2, wraps past 255.
    repeat (300) runCycle();
    checkEq("throughput", hands, 299);

    // Branch at 254 with offset +1 must land at 0.
    forceOn = 1'b1; forcePc = 8'd254; forceOff = 2'b01;
    repeat (300) runCycle();
    checkEq("wrapBranchSeen", forceOn, 0);

    // Three wait states, then reset while a request is pending.
    waitLo = 3; waitHi = 3;
    repeat (30) runCycle();
    #2;
    checkEq("midReqActive", imem_req, 1);
    doReset();

    // Branch at 5 with offset -2 while the next fetch is still waiting.
    forceOn = 1'b1; forcePc = 8'd5; forceOff = 2'b10;
    repeat (60) runCycle();
    checkEq("dropBranchSeen", forceOn, 0);

    // Decode stall fills the queue and parks the fetcher.
    waitLo = 0; waitHi = 0; readyPct = 0;
    repeat (10) runCycle();
    #2;
    checkEq("stallReq", imem_req, 0);
    checkEq("stallValid", instr_valid, 1);
    readyPct = 100;
    runCycle();
    readyPct = 0;
    repeat (6) runCycle();
    readyPct = 100;
    repeat (10) runCycle();

    // Mixed random traffic.
    waitLo = 0; waitHi = 3; readyPct = 70; brPct = 20;
    repeat (2000) runCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
